// File: rtl/cpu_types_pkg.sv
// Machine-wide scalar types shared by the CPU blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/pipe_types_pkg.sv
// Pipeline control types: controller FSM states and halt drain depth.
package pipe_types_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_W      = 2;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// 5-stage pipeline controller: latch enables/flushes, stage valid tracking,
// halt drain sequencing and a fetch-stall cycle counter.
module pipe_ctrl_unit
  import cpu_types_pkg::*;
  import pipe_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       exmem_memop,
  input  logic       ifid_stall,
  input  logic       idex_stall,
  input  logic       exmem_stall,
  input  logic       flushed,
  input  logic       halt_id,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [3:0] stage_valid,
  output logic       halt,
  output word_t      stall_cnt
);
  ctrl_state_t        state_q;
  logic [3:0]         vld_q, vld_d;
  logic [DRAIN_W-1:0] drain_q;
  logic               halt_q;
  logic               freeze, act, in_run;
  logic               hold_ex, hold_id, hold_if;
  logic               start_drain;

  // A data miss on a memory op in EX/MEM stalls the whole pipe in place.
  assign freeze  = vld_q[2] & exmem_memop & ~dhit;
  assign act     = (state_q != HALTED) & ~freeze;
  assign in_run  = (state_q == RUN);

  assign hold_ex = exmem_stall;
  assign hold_id = idex_stall | hold_ex;
  assign hold_if = ifid_stall | hold_id;

  assign memwb_en   = act;
  assign exmem_en   = act & ~hold_ex;
  assign idex_en    = act & (flushed | ~hold_id);
  assign ifid_en    = act & (flushed | ~hold_if);
  assign ifid_flush = act & flushed;
  assign idex_flush = act & flushed;
  assign pc_en      = ihit & ifid_en & in_run;

  assign start_drain = in_run & halt_id & vld_q[0] & idex_en & ~flushed;

  // A stage fed by a held upstream latch receives a bubble.
  always_comb begin
    vld_d = vld_q;
    if (act) begin
      vld_d[3] = exmem_en & vld_q[2];
      if (exmem_en) vld_d[2] = idex_en & vld_q[1];
      if (flushed) begin
        vld_d[1:0] = 2'b00;
      end else begin
        if (idex_en) vld_d[1] = ifid_en & vld_q[0];
        if (ifid_en) vld_d[0] = ihit & in_run;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      vld_q   <= '0;
      drain_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      case (state_q)
        RUN: begin
          if (start_drain) begin
            state_q <= DRAIN;
            drain_q <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          // Count only cycles in which the back end actually advances.
          if (exmem_en) begin
            if (drain_q == '0) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end else begin
              drain_q <= drain_q - DRAIN_W'(1);
            end
          end
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

  sat_counter #(.W($bits(word_t))) u_stall_cnt (
    .clk_i  (CLK),
    .clr_ni (nRST),
    .inc_i  (in_run & ~pc_en),
    .cnt_o  (stall_cnt)
  );

  assign stage_valid = vld_q;
  assign halt        = halt_q;
endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-003 SHALL have port ihit  input  1  instruction fetch completed this cycle.
REQ-004 SHALL have port dhit  input  1  data memory access completed this cycle.
REQ-005 SHALL have port exmem_memop  input  1  EX/MEM holds a load or store.
REQ-006 SHALL have port ifid_stall  input  1  hazard unit holds IF/ID.
REQ-007 SHALL have port idex_stall  input  1  hazard unit holds ID/EX.
REQ-008 SHALL have port exmem_stall  input  1  hazard unit holds EX/MEM.
REQ-009 SHALL have port flushed  input  1  taken branch/jump; squash IF/ID and ID/EX.
REQ-010 SHALL have port halt_id  input  1  halt opcode decoded in ID.
REQ-011 SHALL have port pc_en  output  1  PC update enable.
REQ-012 SHALL have ports ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables.
REQ-013 SHALL have ports ifid_flush, idex_flush  output  1 each  zero the named latch.
REQ-014 SHALL have port stage_valid  output  4  valid bits {memwb, exmem, idex, ifid}.
REQ-015 SHALL have port halt  output  1  sticky CPU halted.
REQ-016 SHALL have port stall_cnt  output  32 (word_t)  saturating fetch-stall cycle count.

Function
REQ-017 freeze = stage_valid[2] & exmem_memop & !dhit; when freeze: all *_en=0, pc_en=0, flush outputs 0, valid bits unchanged.
REQ-018 Hold chain (no freeze): hold_ex=exmem_stall; hold_id=idex_stall|hold_ex; hold_if=ifid_stall|hold_id.
REQ-019 Enables (no freeze, state RUN/DRAIN): memwb_en=1, exmem_en=!hold_ex, idex_en=!hold_id, ifid_en=!hold_if.
REQ-020 Valid propagation: enabled stage k+1 takes valid of stage k if stage k enabled, else 0 (bubble); held stage keeps its valid.
REQ-021 IF/ID next valid = ihit & state==RUN when ifid_en=1 (fetch miss inserts bubble).
REQ-022 pc_en = ihit & ifid_en & state==RUN & !freeze.
REQ-023 flushed (no freeze): ifid_flush=idex_flush=1, ifid_en=idex_en=1, IF/ID and ID/EX valid cleared next cycle; flush overrides ifid_stall/idex_stall; pc_en still per REQ-022 with hold_if ignored for IF/ID.
REQ-024 FSM states RUN, DRAIN, HALTED; enables/flush combinational, all other outputs registered.
REQ-025 RUN->DRAIN when halt_id & stage_valid[0] & idex_en & !flushed & !freeze; drain counter loaded with 3.
REQ-026 DRAIN: pc_en=0; counter decrements on each non-freeze cycle with exmem_en=1; counter==0 at such a cycle -> HALTED.
REQ-027 HALTED: all enables 0, flush 0, halt=1 until reset; inputs ignored.
REQ-028 stall_cnt increments by 1 each cycle in RUN with pc_en=0; saturates at 0xFFFFFFFF (no wrap).
REQ-029 Simultaneous flushed and halt_id: flush wins, state stays RUN.

Reset
REQ-030 nRST low asynchronously forces state RUN, stage_valid 4'b0000, halt 0, stall_cnt 0, drain counter 0.
REQ-031 Reset mid-DRAIN or in HALTED returns to RUN on first edge after nRST high; in-flight valids discarded.

Structure
REQ-032 ctrl_state_t enum (RUN, DRAIN, HALTED) and DRAIN_CYCLES=3 SHALL live in pipe_types_pkg; word_t from cpu_types_pkg.
REQ-033 Saturating counter SHALL be one sub-module, sat_counter (width parameter, inc enable, async active-low clear).

Verification
REQ-034 ihit=1, no hazards, 6 cycles after reset -> stage_valid 0001,0011,0111,1111,1111; pc_en=1 every cycle; stall_cnt=0.
REQ-035 Full pipe, exmem_memop=1, dhit=0 for 3 cycles -> all enables 0, stage_valid stays 1111; dhit=1 -> resume, stall_cnt=3.
REQ-036 Full pipe, idex_stall=1 one cycle -> ifid_en=idex_en=0, exmem_en=1; next stage_valid=1011; stall_cnt=1.
REQ-037 Full pipe, flushed=1 with ifid_stall=1 -> ifid_flush=idex_flush=1, next stage_valid=1100.
REQ-038 halt_id with stage_valid=1111, no stalls -> pc_en=0 from next cycle, halt=1 exactly 4 cycles later; stall_cnt unchanged after DRAIN entry.
REQ-039 stall_cnt preset near 0xFFFFFFFE, 3 ihit=0 cycles -> reads 0xFFFFFFFF, no wrap; nRST pulse in HALTED -> halt=0, stall_cnt=0.
